quad_gen: RTL

QUAD_GEN -- requirements
Module: quad_gen

---
 rtl/qg_pkg.sv | 22 ++
 rtl/qg_if.sv | 35 +++
 rtl/qg_div.sv | 34 +++
 rtl/quad_gen.sv | 127 ++++++++++++
 4 files changed

// File: rtl/qg_pkg.sv
// Shared definitions for the quadrature step generator: state encoding,
// phase-sequence tables and default widths.
package qg_pkg;

   localparam int unsigned W_DEF    = 16;
   localparam int unsigned DIVW_DEF = 16;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   // Next {i,q}, indexed by current {i,q}; slot n occupies bits [2n+1:2n].
   localparam logic [7:0] FWD_NEXT = {2'b01, 2'b11, 2'b00, 2'b10};
   localparam logic [7:0] REV_NEXT = {2'b10, 2'b00, 2'b11, 2'b01};

   function automatic logic [1:0] next_phase(input logic [1:0] ph, input logic rev);
      logic [2:0] base;
      base = {ph, 1'b0};
      return rev ? REV_NEXT[base +: 2] : FWD_NEXT[base +: 2];
   endfunction

endpackage

// File: rtl/qg_if.sv
// Command/status bundle between a move controller and quad_gen.
// QG_INDEX_EN adds the index output z.
interface qg_if
   import qg_pkg::*;
#(
   parameter int unsigned W    = W_DEF,
   parameter int unsigned DIVW = DIVW_DEF
);
   logic            load;
   logic [W-1:0]    delta;
   logic [DIVW-1:0] period;
   logic            abort;
   logic            busy;
   logic            done;
   logic            i;
   logic            q;
   logic            i_r;
   logic            i_f;
   logic            q_r;
   logic            q_f;
   logic [W-1:0]    pos;
`ifdef QG_INDEX_EN
   logic            z;

   modport master (output load, delta, period, abort,
                   input  busy, done, i, q, i_r, i_f, q_r, q_f, pos, z);
   modport slave  (input  load, delta, period, abort,
                   output busy, done, i, q, i_r, i_f, q_r, q_f, pos, z);
`else
   modport master (output load, delta, period, abort,
                   input  busy, done, i, q, i_r, i_f, q_r, q_f, pos);
   modport slave  (input  load, delta, period, abort,
                   output busy, done, i, q, i_r, i_f, q_r, q_f, pos);
`endif
endinterface

// File: rtl/qg_div.sv
// Reloadable down-counter: start loads the first interval (one extra cycle),
// then tick_c fires once every reload clocks while enabled.
module qg_div
   import qg_pkg::*;
#(
   parameter int unsigned DIVW = DIVW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [DIVW-1:0] reload,
   input  logic            enable,
   output logic            tick_c
);
   logic [DIVW-1:0] cnt_q;
   logic [DIVW-1:0] cnt_d;

   assign tick_c = enable && (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (start) begin
         cnt_d = reload;
      end else if (enable) begin
         cnt_d = (cnt_q == '0) ? reload - DIVW'(1) : cnt_q - DIVW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/quad_gen.sv
// Quadrature step generator: emits |delta| quarter-steps on i/q at a
// programmable rate and tracks position. QG_INDEX_EN adds index output z.
module quad_gen
   import qg_pkg::*;
#(
   parameter int unsigned W    = W_DEF,
   parameter int unsigned DIVW = DIVW_DEF
`ifdef QG_INDEX_EN
 , parameter int unsigned IDXW = 4
`endif
) (
   input logic clk,
   input logic rst,
   qg_if.slave bus
);
   logic [1:0]      state_q,  state_d;
   logic [W-1:0]    remain_q, remain_d;
   logic            dir_q,    dir_d;
   logic [DIVW-1:0] reload_q, reload_d;
   logic [1:0]      ph_q,     ph_d;
   logic [W-1:0]    pos_q,    pos_d;
   logic [3:0]      stb_q,    stb_d;
   logic            busy_q,   busy_d;
   logic            done_q,   done_d;

   logic            div_start;
   logic            div_en;
   logic            tick;
   logic [W-1:0]    mag;

   // Magnitude kept unsigned so the most negative delta still counts correctly.
   assign mag = bus.delta[W-1] ? W'(-bus.delta) : bus.delta;

   qg_div #(.DIVW(DIVW)) u_div (
      .clk    (clk),
      .rst    (rst),
      .start  (div_start),
      .reload (reload_d),
      .enable (div_en),
      .tick_c (tick)
   );

   always_comb begin
      state_d   = state_q;
      remain_d  = remain_q;
      dir_d     = dir_q;
      reload_d  = reload_q;
      ph_d      = ph_q;
      pos_d     = pos_q;
      div_start = 1'b0;
      div_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.load && !bus.abort) begin
               if (bus.delta != '0) begin
                  remain_d  = mag;
                  dir_d     = bus.delta[W-1];
                  reload_d  = (bus.period == '0) ? DIVW'(1) : bus.period;
                  div_start = 1'b1;
                  state_d   = ST_RUN;
               end else begin
                  state_d   = ST_FIN;
               end
            end
         end
         ST_RUN: begin
            if (bus.abort) begin
               state_d = ST_FIN;
            end else begin
               div_en = 1'b1;
               if (tick) begin
                  ph_d     = next_phase(ph_q, dir_q);
                  pos_d    = dir_q ? pos_q - W'(1) : pos_q + W'(1);
                  remain_d = remain_q - W'(1);
                  if (remain_q == W'(1)) state_d = ST_FIN;
               end
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Strobe order {i_r, i_f, q_r, q_f}; all zero when the phase holds.
      stb_d  = {~ph_q[1] & ph_d[1], ph_q[1] & ~ph_d[1],
                ~ph_q[0] & ph_d[0], ph_q[0] & ~ph_d[0]};
      busy_d = (state_d != ST_IDLE) || (state_q == ST_FIN);
      done_d = (state_q == ST_FIN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         remain_q <= '0;
         dir_q    <= 1'b0;
         reload_q <= '0;
         ph_q     <= 2'b00;
         pos_q    <= '0;
         stb_q    <= 4'b0000;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         dir_q    <= dir_d;
         reload_q <= reload_d;
         ph_q     <= ph_d;
         pos_q    <= pos_d;
         stb_q    <= stb_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.i    = ph_q[1];
   assign bus.q    = ph_q[0];
   assign bus.i_r  = stb_q[3];
   assign bus.i_f  = stb_q[2];
   assign bus.q_r  = stb_q[1];
   assign bus.q_f  = stb_q[0];
   assign bus.pos  = pos_q;
`ifdef QG_INDEX_EN
   assign bus.z    = (pos_q[IDXW-1:0] == '0) && (ph_q == 2'b00);
`endif

endmodule
